// File: rtl/vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_filler
// Description : Draws one clipped rectangle per start command, one pixel per
//               clock, on the VGA adapter x/y/colour/plot interface. Supports
//               solid, cycling-colour, checkerboard and full-screen clear fills,
//               with abort and a done/busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_filler #(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int COL_W = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [X_W-1:0]   x0,
  input  logic [Y_W-1:0]   y0,
  input  logic [X_W-1:0]   w,
  input  logic [Y_W-1:0]   h,
  input  logic [COL_W-1:0] colour_in,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pixel_count
);

  localparam logic [X_W:0]     c_x_max   = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]     c_y_max   = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0]   c_x_one   = X_W'(1);
  localparam logic [Y_W-1:0]   c_y_one   = Y_W'(1);
  localparam logic [COL_W-1:0] c_col_one = COL_W'(1);
  localparam logic [COL_W-1:0] c_col_top = {COL_W{1'b1}};
  localparam logic [1:0]       c_mode_solid   = 2'd0;
  localparam logic [1:0]       c_mode_cycle   = 2'd1;
  localparam logic [1:0]       c_mode_clear   = 2'd2;
  localparam logic [1:0]       c_mode_checker = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [X_W-1:0]     xs_q, xs_d, xe_q, xe_d, cx_q, cx_d, x_q, x_d;
  logic [Y_W-1:0]     ys_q, ys_d, ye_q, ye_d, cy_q, cy_d, y_q, y_d;
  logic [COL_W-1:0]   col_q, col_d, cc_q, cc_d, colour_q, colour_d;
  logic               plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]        count_q, count_d;

  logic [X_W:0]       x_end_raw;
  logic [Y_W:0]       y_end_raw;
  logic [X_W-1:0]     xs_n, xe_n;
  logic [Y_W-1:0]     ys_n, ye_n;
  logic [COL_W-1:0]   col_n, pix_col;
  logic               empty_n;

  // Clip the requested geometry against the screen; clear mode forces full screen.
  always_comb begin
    x_end_raw = {1'b0, x0} + {1'b0, w} - {{X_W{1'b0}}, 1'b1};
    y_end_raw = {1'b0, y0} + {1'b0, h} - {{Y_W{1'b0}}, 1'b1};
    xs_n      = x0;
    ys_n      = y0;
    xe_n      = (x_end_raw > c_x_max) ? c_x_max[X_W-1:0] : x_end_raw[X_W-1:0];
    ye_n      = (y_end_raw > c_y_max) ? c_y_max[Y_W-1:0] : y_end_raw[Y_W-1:0];
    empty_n   = (w == '0) || (h == '0) || ({1'b0, x0} > c_x_max) || ({1'b0, y0} > c_y_max);
    col_n     = colour_in;
    if (mode == c_mode_clear) begin
      xs_n    = '0;
      ys_n    = '0;
      xe_n    = c_x_max[X_W-1:0];
      ye_n    = c_y_max[Y_W-1:0];
      empty_n = 1'b0;
      col_n   = '0;
    end
  end

  // Colour of the pixel at the current scan position.
  always_comb begin
    pix_col = col_q;
    case (mode_q)
      c_mode_solid:   pix_col = col_q;
      c_mode_cycle:   pix_col = cc_q;
      c_mode_clear:   pix_col = '0;
      c_mode_checker: pix_col = (cx_q[0] ^ cy_q[0]) ? '0 : col_q;
      default:        pix_col = col_q;
    endcase
  end

  // Next-state logic: scan counters run one cycle ahead of the registered pixel outputs.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    xs_d     = xs_q;
    xe_d     = xe_q;
    ys_d     = ys_q;
    ye_d     = ye_q;
    col_d    = col_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    cc_d     = cc_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    if (plot_q && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
    case (state_q)
      S_IDLE: begin
        // busy_q still high here right after a completion; such a start is dropped
        if (start && !busy_q) begin
          mode_d  = mode;
          xs_d    = xs_n;
          xe_d    = xe_n;
          ys_d    = ys_n;
          ye_d    = ye_n;
          col_d   = col_n;
          cx_d    = xs_n;
          cy_d    = ys_n;
          cc_d    = (col_n == '0) ? c_col_one : col_n;
          count_d = '0;
          state_d = empty_n ? S_DONE : S_DRAW;
        end
      end
      S_DRAW: begin
        if (abort && plot_q) begin
          // pixel on the bus at this edge is counted above; nothing further is shown
          done_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          x_d      = cx_q;
          y_d      = cy_q;
          colour_d = pix_col;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          cc_d     = (cc_q == c_col_top) ? c_col_one : cc_q + c_col_one;
          if (cy_q == ye_q) begin
            cy_d = ys_q;
            if (cx_q == xe_q) begin
              state_d = S_DONE;
            end else begin
              cx_d = cx_q + c_x_one;
            end
          end else begin
            cy_d = cy_q + c_y_one;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      xs_q     <= '0;
      xe_q     <= '0;
      ys_q     <= '0;
      ye_q     <= '0;
      col_q    <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      cc_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      xs_q     <= xs_d;
      xe_q     <= xe_d;
      ys_q     <= ys_d;
      ye_q     <= ye_d;
      col_q    <= col_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      cc_q     <= cc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pixel_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_rect_filler
// Description : Self-checking bench for vga_rect_filler; directed and random
//               rectangle commands compared against a loop-based pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_rect_filler;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic [1:0]  mode     = '0;
  logic [7:0]  x0       = '0;
  logic [6:0]  y0       = '0;
  logic [7:0]  w        = '0;
  logic [6:0]  h        = '0;
  logic [2:0]  colour_in = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;
  logic [15:0] pixel_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  vga_rect_filler dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .x0          (x0),
    .y0          (y0),
    .w           (w),
    .h           (h),
    .colour_in   (colour_in),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done),
    .pixel_count (pixel_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected pixel stream: clipped rectangle, column-major, colour by mode rule.
  task automatic build_model(input int md, input int x0i, input int y0i,
                             input int wi, input int hi, input int ci);
    int xs, ys, xe, ye, c0, col, k;
    exp_q.delete();
    if (md == 2) begin
      xs = 0; ys = 0; xe = 159; ye = 119;
    end else begin
      if (wi == 0 || hi == 0 || x0i > 159 || y0i > 119) return;
      xs = x0i; ys = y0i;
      xe = (x0i + wi - 1 > 159) ? 159 : x0i + wi - 1;
      ye = (y0i + hi - 1 > 119) ? 119 : y0i + hi - 1;
    end
    c0 = (ci == 0) ? 1 : ci;
    k  = 0;
    for (int xx = xs; xx <= xe; xx++) begin
      for (int yy = ys; yy <= ye; yy++) begin
        case (md)
          0:       col = ci;
          1:       col = ((c0 - 1 + k) % 7) + 1;
          2:       col = 0;
          default: col = (((xx ^ yy) & 1) != 0) ? 0 : ci;
        endcase
        exp_q.push_back((xx << 16) | (yy << 8) | col);
        k++;
      end
    end
  endtask

  // Issue one command and check the pixel stream, timing and final count.
  task automatic run_op(input int md, input int x0i, input int y0i, input int wi,
                        input int hi, input int ci, input int abort_at,
                        input int glitch_at, input bit start_abort);
    int cyc, got, busy_n, done_cyc, n_exp;
    bit ab_clr, st_clr;
    logic [31:0] word;
    build_model(md, x0i, y0i, wi, hi, ci);
    n_exp = exp_q.size();
    if (abort_at > 0 && abort_at < n_exp) n_exp = abort_at;
    mode = md[1:0]; x0 = x0i[7:0]; y0 = y0i[6:0]; w = wi[7:0]; h = hi[6:0];
    colour_in = ci[2:0];
    start = 1'b1;
    abort = start_abort;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    abort = 1'b0;
    cyc = 0; got = 0; busy_n = 0; done_cyc = 0; ab_clr = 0; st_clr = 0;
    while (done_cyc == 0 && cyc < 25000) begin
      @(posedge CLOCK_50);
      #1;
      cyc++;
      if (ab_clr) begin abort = 1'b0; ab_clr = 0; end
      if (st_clr) begin
        start = 1'b0; mode = md[1:0]; x0 = x0i[7:0]; y0 = y0i[6:0];
        w = wi[7:0]; h = hi[6:0]; st_clr = 0;
      end
      if (busy) busy_n++;
      if (done) done_cyc = cyc;
      if (plot) begin
        word = {8'h00, x, 1'b0, y, 5'b00000, colour};
        if (got < exp_q.size()) check("pixel", word, exp_q[got]);
        else check("extra_plot", got + 1, exp_q.size());
        got++;
        if (got == abort_at) begin abort = 1'b1; ab_clr = 1; end
        if (got == glitch_at) begin
          start = 1'b1; mode = 2'd2; x0 = 8'd0; y0 = 7'd0; w = 8'd1; h = 7'd1;
          st_clr = 1;
        end
      end
    end
    check("plot_total", got, n_exp);
    check("done_latency", done_cyc, n_exp + 1);
    check("busy_cycles", busy_n, n_exp + 1);
    check("pixel_count", pixel_count, n_exp);
    @(posedge CLOCK_50);
    #1;
    check("idle_flags", {29'd0, done, busy, plot}, 32'd0);
  endtask

  initial begin
    int plots;
    int md, ai;
    // reset state
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_outputs", {x, 1'b0, y, colour, plot, busy, done}, 32'd0);
    check("reset_count", pixel_count, 0);
    reset = 1'b0;

    // directed
    run_op(0, 10, 20, 3, 2, 5, 0, 0, 0);
    run_op(0, 158, 118, 5, 5, 2, 0, 0, 0);
    run_op(0, 200, 10, 3, 3, 4, 0, 0, 0);
    run_op(0, 5, 125, 2, 2, 1, 0, 0, 0);
    run_op(0, 5, 5, 0, 3, 1, 0, 0, 0);
    run_op(1, 30, 40, 1, 4, 6, 0, 0, 0);
    run_op(1, 30, 40, 2, 5, 0, 0, 0, 0);
    run_op(3, 0, 0, 2, 2, 3, 0, 0, 0);
    run_op(2, 77, 33, 5, 9, 6, 0, 0, 0);
    run_op(0, 50, 50, 10, 10, 4, 5, 0, 0);
    run_op(0, 20, 20, 10, 10, 3, 0, 3, 0);
    run_op(0, 1, 1, 2, 2, 7, 0, 0, 1);

    // reset in the middle of a draw
    mode = 2'd0; x0 = 8'd0; y0 = 7'd0; w = 8'd10; h = 7'd10; colour_in = 3'd5;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #2;
    check("pre_reset_plot", plot, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {x, 1'b0, y, colour, plot, busy, done}, 32'd0);
    check("async_reset_count", pixel_count, 0);
    plots = 0;
    repeat (5) begin
      @(posedge CLOCK_50);
      #1;
      if (plot) plots++;
    end
    check("plots_in_reset", plots, 0);
    reset = 1'b0;
    run_op(0, 3, 4, 2, 3, 6, 0, 0, 0);

    // randomized commands
    for (int i = 0; i < 30; i++) begin
      md = $urandom_range(0, 3);
      if (md == 2) md = 0;
      ai = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run_op(md, $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 12),
             $urandom_range(0, 12), $urandom_range(0, 7), ai, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
